// File: rtl/loader_pkg.sv
// Shared encodings for the host-side memory loader: command opcodes and FSM states.
package loader_pkg;

  localparam logic [1:0] OP_WR_IMEM = 2'b00;
  localparam logic [1:0] OP_WR_DMEM = 2'b01;
  localparam logic [1:0] OP_RD_DMEM = 2'b10;
  localparam logic [1:0] OP_RUN     = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low clear.
module reg_arstn_en #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/mem_loader.sv
// Host command engine: loads CPU instruction/data memories, reads data memory back,
// and runs the CPU for a counted number of cycles, answering on a response channel.
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              enable,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [63:0]       wdata_ext_2,
  input  logic [63:0]       rdata_ext_2
);

  logic [2:0]       state;
  logic             rst_done;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] count_q;
  logic             accept;
  logic             is_imem_wr;
  logic             is_dmem_wr;
  logic             is_dmem_rd;
  logic             is_run;

  assign cmd_ready  = rst_done && (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign is_imem_wr = (cmd_op == OP_WR_IMEM);
  assign is_dmem_wr = (cmd_op == OP_WR_DMEM);
  assign is_dmem_rd = (cmd_op == OP_RD_DMEM);
  assign is_run     = (cmd_op == OP_RUN);

  // Address/data registers load only on their own access type, so each port
  // keeps its last address while other commands run.
  reg_arstn_en #(.W(2)) u_op (
    .clk(clk), .arst_n(arst_n), .en(accept), .d(cmd_op), .q(op_q)
  );
  reg_arstn_en #(.W(ADDR_W)) u_addr_imem (
    .clk(clk), .arst_n(arst_n), .en(accept && is_imem_wr), .d(cmd_addr), .q(addr_ext)
  );
  reg_arstn_en #(.W(32)) u_wdata_imem (
    .clk(clk), .arst_n(arst_n), .en(accept && is_imem_wr), .d(cmd_wdata[31:0]), .q(wdata_ext)
  );
  reg_arstn_en #(.W(ADDR_W)) u_addr_dmem (
    .clk(clk), .arst_n(arst_n), .en(accept && (is_dmem_wr || is_dmem_rd)), .d(cmd_addr),
    .q(addr_ext_2)
  );
  reg_arstn_en #(.W(64)) u_wdata_dmem (
    .clk(clk), .arst_n(arst_n), .en(accept && is_dmem_wr), .d(cmd_wdata), .q(wdata_ext_2)
  );
  reg_arstn_en #(.W(CNT_W)) u_count (
    .clk(clk), .arst_n(arst_n), .en(accept && is_run), .d(cmd_wdata[CNT_W-1:0]), .q(count_q)
  );

  // Strobes decode from registered state/op only; reset forces IDLE so all drop at once.
  assign wen_ext   = (state == ST_WRITE) && (op_q == OP_WR_IMEM);
  assign wen_ext_2 = (state == ST_WRITE) && (op_q == OP_WR_DMEM);
  assign ren_ext_2 = (state == ST_RD_REQ);
  assign ren_ext   = 1'b0;
  assign enable    = (state == ST_RUN);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= ST_IDLE;
      counter   <= '0;
      rst_done  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_imem_wr || is_dmem_wr) begin
              state <= ST_WRITE;
            end else if (is_dmem_rd) begin
              state <= ST_RD_REQ;
            end else if (cmd_wdata[CNT_W-1:0] == '0) begin
              state     <= ST_RESP;
              rsp_rdata <= '0;
            end else begin
              counter <= cmd_wdata[CNT_W-1:0];
              state   <= ST_RUN;
            end
          end
        end
        ST_WRITE:   state <= ST_IDLE;
        ST_RD_REQ:  state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          rsp_rdata <= rdata_ext_2;
          state     <= ST_RESP;
        end
        ST_RUN: begin
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state     <= ST_RESP;
            rsp_rdata <= 64'(count_q);
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed commands push expected memory writes and
// responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_loader;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              arst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [63:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              enable;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [31:0]       wdata_ext;
  logic [ADDR_W-1:0] addr_ext_2;
  logic              wen_ext_2;
  logic              ren_ext_2;
  logic [63:0]       wdata_ext_2;
  logic [63:0]       rdata_ext_2;

  mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with one-cycle synchronous read
  logic [63:0] dmem [0:31];
  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = 64'h0;
    rdata_ext_2 = 64'h0;
  end
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[7:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[7:3]];
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;
  typedef struct {
    logic [63:0] data;
    int unsigned en_cycles;
  } rsp_t;

  wr_t  imem_q[$];
  wr_t  dmem_q[$];
  rsp_t rsp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned en_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output event, expected none queued", name);
  endfunction

  // Monitor
  initial begin
    wr_t  w;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        en_cnt = 0;
      end else begin
        if (enable) begin
          en_cnt++;
          check("no_mem_access_in_run", {60'h0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'h0);
        end
        if (wen_ext) begin
          if (imem_q.size() == 0) unexpected("imem_write_unexpected");
          else begin
            w = imem_q.pop_front();
            check("imem_addr", addr_ext, w.addr);
            check("imem_wdata", {32'h0, wdata_ext}, w.data);
          end
        end
        if (wen_ext_2) begin
          if (dmem_q.size() == 0) unexpected("dmem_write_unexpected");
          else begin
            w = dmem_q.pop_front();
            check("dmem_addr", addr_ext_2, w.addr);
            check("dmem_wdata", wdata_ext_2, w.data);
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) unexpected("rsp_unexpected");
          else begin
            r = rsp_q.pop_front();
            check("rsp_rdata", rsp_rdata, r.data);
            check("run_enable_cycles", 64'(en_cnt), 64'(r.en_cycles));
          end
          en_cnt = 0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata);
    bit ok;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(ok), 64'h1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    check("rsp_arrives", 64'(rsp_valid), 64'h1);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    idle_cycles(2);
    check("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    check("rst_enable", 64'(enable), 64'h0);
    check("rst_strobes", {60'h0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_addr_ext", addr_ext, 64'h0);
    check("rst_addr_ext_2", addr_ext_2, 64'h0);
    check("rst_wdata_ext_2", wdata_ext_2, 64'h0);
    check("rst_rsp_rdata", rsp_rdata, 64'h0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    idle_cycles(2);
    check("cmd_ready_after_release", 64'(cmd_ready), 64'h1);

    // IMEM write, no response expected
    imem_q.push_back('{addr: 64'h8, data: 64'h0000_0000_0050_0093});
    send_cmd(2'b00, 64'h8, 64'h0000_0000_0050_0093);
    @(negedge clk);
    check("imem_wen_pulse", 64'(wen_ext), 64'h1);
    @(negedge clk);
    check("imem_wen_one_cycle", 64'(wen_ext), 64'h0);
    idle_cycles(2);
    check("imem_no_rsp", 64'(rsp_valid), 64'h0);
    check("imem_q_drained", 64'(imem_q.size()), 64'h0);

    // DMEM write then readback with three-cycle latency
    dmem_q.push_back('{addr: 64'h10, data: 64'hDEAD_BEEF_CAFE_F00D});
    send_cmd(2'b01, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    idle_cycles(2);
    rsp_q.push_back('{data: 64'hDEAD_BEEF_CAFE_F00D, en_cycles: 0});
    send_cmd(2'b10, 64'h10, 64'h0);
    @(negedge clk);
    check("rd_cycle1_ren", 64'(ren_ext_2), 64'h1);
    check("rd_cycle1_no_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("rd_cycle2_no_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("rd_cycle3_rsp", 64'(rsp_valid), 64'h1);
    check("rd_cycle3_data", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    idle_cycles(2);
    check("addr_ext_held", addr_ext, 64'h8);
    check("addr_ext_2_held", addr_ext_2, 64'h10);

    // Normal run of 5 cycles
    rsp_q.push_back('{data: 64'd5, en_cycles: 5});
    send_cmd(2'b11, 64'h0, 64'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("run5_enable_high", 64'(enable), 64'h1);
    end
    @(negedge clk);
    check("run5_enable_drop", 64'(enable), 64'h0);
    check("run5_rsp_valid", 64'(rsp_valid), 64'h1);
    idle_cycles(2);

    // Zero-count run
    rsp_q.push_back('{data: 64'd0, en_cycles: 0});
    send_cmd(2'b11, 64'h0, 64'd0);
    @(negedge clk);
    check("run0_enable", 64'(enable), 64'h0);
    check("run0_rsp_valid", 64'(rsp_valid), 64'h1);
    check("run0_rsp_rdata", rsp_rdata, 64'h0);
    idle_cycles(2);

    // Response backpressure
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    rsp_q.push_back('{data: 64'd2, en_cycles: 2});
    send_cmd(2'b11, 64'h0, 64'd2);
    wait_rsp();
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      check("bp_rsp_rdata", rsp_rdata, 64'd2);
      check("bp_cmd_ready", 64'(cmd_ready), 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_cmd_ready", 64'(cmd_ready), 64'h1);
    check("bp_idle_rsp_valid", 64'(rsp_valid), 64'h0);

    // Reset in cycle 3 of a 10-cycle run
    send_cmd(2'b11, 64'h0, 64'd10);
    idle_cycles(3);
    check("midrun_enable_before", 64'(enable), 64'h1);
    #2 arst_n = 1'b0;
    #1;
    check("midrun_enable_immediate", 64'(enable), 64'h0);
    check("midrun_rsp_valid", 64'(rsp_valid), 64'h0);
    idle_cycles(2);
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("midrun_rsp_dropped", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("midrun_cmd_ready", 64'(cmd_ready), 64'h1);
    check("midrun_enable_after", 64'(enable), 64'h0);

    // Operation after reset
    imem_q.push_back('{addr: 64'h20, data: 64'h0000_0000_1234_5678});
    send_cmd(2'b00, 64'h20, 64'hAAAA_BBBB_1234_5678);
    idle_cycles(3);
    check("final_imem_q_empty", 64'(imem_q.size()), 64'h0);
    check("final_dmem_q_empty", 64'(dmem_q.size()), 64'h0);
    check("final_rsp_q_empty", 64'(rsp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the width of the external memory address ports.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the run-cycle counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have cmd_valid (input, 1), cmd_ready (output, 1), cmd_op (input, 2), cmd_addr (input, ADDR_W) and cmd_wdata (input, 64) as the host command channel.
REQ-006 SHALL define cmd_op encodings: 00 write IMEM, 01 write DMEM, 10 read DMEM, 11 run.
REQ-007 SHALL have rsp_valid (output, 1), rsp_ready (input, 1) and rsp_rdata (output, 64) as the host response channel.
REQ-008 SHALL have enable (output, 1) driving the CPU run enable.
REQ-009 SHALL have addr_ext (output, ADDR_W), wen_ext (output, 1), ren_ext (output, 1) and wdata_ext (output, 32) driving the CPU instruction-memory external port.
REQ-010 SHALL have addr_ext_2 (output, ADDR_W), wen_ext_2 (output, 1), ren_ext_2 (output, 1), wdata_ext_2 (output, 64) and rdata_ext_2 (input, 64) for the CPU data-memory external port.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, RD_REQ, RD_WAIT, RUN and RESP.
REQ-012 SHALL assert cmd_ready only in IDLE.
REQ-013 SHALL accept a command on the clk edge where cmd_valid and cmd_ready are both high, registering op, addr and wdata.
REQ-014 SHALL, on op 00, enter WRITE, drive wen_ext=1 for exactly one cycle with addr_ext=addr and wdata_ext=wdata[31:0], then return to IDLE without issuing a response.
REQ-015 SHALL, on op 01, enter WRITE, drive wen_ext_2=1 for exactly one cycle with addr_ext_2=addr and wdata_ext_2=wdata, then return to IDLE without issuing a response.
REQ-016 SHALL, on op 10, drive ren_ext_2=1 for one cycle in RD_REQ, capture rdata_ext_2 at the end of RD_WAIT (one-cycle synchronous read latency), then enter RESP.
REQ-017 SHALL, on op 11, load the counter with wdata[CNT_W-1:0], enter RUN, and hold enable=1 for exactly that many cycles, then enter RESP with rsp_rdata = the loaded count, zero-extended.
REQ-018 SHALL, on op 11 with a count of 0, never assert enable and go directly to RESP with rsp_rdata=0.
REQ-019 SHALL hold rsp_valid=1 with a stable rsp_rdata in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-020 SHALL keep all wen/ren outputs at 0 in RUN, and keep enable at 0 outside RUN, so external memory access never overlaps CPU execution.
REQ-021 SHALL keep all wen/ren outputs at 0 in IDLE, RD_WAIT and RESP.
REQ-022 SHALL drive all command outputs from registers, with no combinational path from cmd_* or rsp_ready to any memory-port output.
REQ-023 SHALL keep addr_ext and addr_ext_2 at their last value when no access is in progress.
REQ-024 SHALL ignore cmd_valid outside IDLE; the host must hold the command until cmd_ready.

Reset
REQ-025 SHALL, while arst_n=0, asynchronously force state=IDLE and counter=0.
REQ-026 SHALL, while arst_n=0, force enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2 and rsp_valid to 0.
REQ-027 SHALL, while arst_n=0, force addr_ext, addr_ext_2, wdata_ext, wdata_ext_2 and rsp_rdata to 0.
REQ-028 SHALL, when reset is asserted mid-RUN or mid-read, deassert enable/ren in that same instant and drop the pending response.
REQ-029 SHALL leave cmd_ready low while arst_n=0 and raise it in the first cycle after release.

Structure
REQ-030 SHALL place the cmd_op encodings and FSM state encodings in a shared package, loader_pkg.
REQ-031 SHALL contain no sub-modules except the existing reg_arstn_en register cell, used for the command capture registers.

Verification
REQ-032 SHALL check IMEM write: cmd (00, addr 0x8, wdata 0x00500093) -> one-cycle wen_ext pulse, addr_ext=0x8, wdata_ext=0x00500093, and no response.
REQ-033 SHALL check DMEM write/readback: write (01, 0x10, 0xDEADBEEFCAFEF00D), then read (10, 0x10) -> rsp_rdata=0xDEADBEEFCAFEF00D exactly three cycles after the read is accepted.
REQ-034 SHALL check a normal run: cmd (11, wdata 5) -> enable high for exactly 5 cycles, then rsp_valid with rsp_rdata=5.
REQ-035 SHALL check a zero-count run: cmd (11, wdata 0) -> enable never high, and rsp_valid with rsp_rdata=0 on the next cycle.
REQ-036 SHALL check response backpressure: rsp_ready held at 0 for 4 cycles -> rsp_valid and rsp_rdata stable and cmd_ready low throughout, then IDLE one cycle after rsp_ready=1.
REQ-037 SHALL check reset mid-run: arst_n pulled low during cycle 3 of a 10-cycle run -> enable at 0 immediately, rsp_valid stays 0, and cmd_ready=1 after release.
